// File: rtl/rs485_pkg.sv
// rtl/rs485_pkg.sv - shared types and helpers for the RS485 transmit scheduler
package rs485_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_GUARD,
    LOAD,
    WAIT_DONE,
    POST_GUARD
  } state_t;

  // Wide enough for the byte timeout at the slowest supported baud rates
  localparam int CNT_W = 24;

  function automatic int unsigned bit_cyc(input int unsigned clk_freq, input int unsigned bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/rs485_tx_fifo.sv
// rtl/rs485_tx_fifo.sv - byte FIFO feeding the transmit scheduler
module rs485_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic [AW:0]   level_d;

  // A push while full is accepted only when the head leaves in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_d = level;
    if (push_ok && !pop_ok) begin
      level_d = level + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_d = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_d;
      full  <= (level_d == FULL_LEVEL);
      empty <= (level_d == '0);
    end
  end

endmodule

// File: rtl/rs485_tx_scheduler.sv
// rtl/rs485_tx_scheduler.sv - buffers bytes for uart_tx and owns the RS485 driver enable
module rs485_tx_scheduler
  import rs485_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned UART_BPS        = 115200,
  parameter int          FIFO_DEPTH      = 16,
  parameter int unsigned PRE_GUARD_CYC   = 50,
  parameter int unsigned POST_GUARD_BITS = 1,
  parameter int unsigned TIMEOUT_BITS    = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          uart_tx_start,
  output logic [7:0]                    uart_tx_data,
  input  logic                          uart_tx_busy,
  input  logic                          uart_tx_done,
  output logic                          en_rs485,
  output logic                          tx_timeout,
  output logic                          overflow
);

  localparam int unsigned BIT_CYC  = bit_cyc(CLK_FREQ, UART_BPS);
  localparam int unsigned POST_CYC = POST_GUARD_BITS * BIT_CYC;
  localparam int unsigned TO_CYC   = TIMEOUT_BITS * BIT_CYC;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             pop;
  logic             start_d;
  logic             timeout_d;
  logic             fifo_empty;
  logic [7:0]       head;
  logic             last_pre;
  logic             last_post;
  logic             last_to;

  rs485_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // cnt counts cycles already spent in the current timed state
  assign last_pre  = (32'(cnt) + 32'd1 >= PRE_GUARD_CYC);
  assign last_post = (32'(cnt) + 32'd1 >= POST_CYC);
  assign last_to   = (32'(cnt) + 32'd1 >= TO_CYC);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pop       = 1'b0;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && !uart_tx_busy) begin
          state_d = (PRE_GUARD_CYC == 0) ? LOAD : PRE_GUARD;
          cnt_d   = '0;
        end
      end
      PRE_GUARD: begin
        if (last_pre) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      LOAD: begin
        if (!uart_tx_busy) begin
          pop     = 1'b1;
          start_d = 1'b1;
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end
      end
      WAIT_DONE: begin
        if (uart_tx_done) begin
          state_d = fifo_empty ? POST_GUARD : LOAD;
          cnt_d   = '0;
        end else if (last_to) begin
          timeout_d = 1'b1;
          state_d   = POST_GUARD;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      POST_GUARD: begin
        // New data extends the burst without another pre-guard
        if (!fifo_empty) begin
          state_d = LOAD;
        end else if (last_post) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
      en_rs485      <= 1'b0;
      tx_timeout    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      uart_tx_start <= start_d;
      tx_timeout    <= timeout_d;
      en_rs485      <= (state_d != IDLE);
      if (pop) begin
        uart_tx_data <= head;
      end
      if (wr_en && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs485_tx_scheduler.sv
// tb/tb_rs485_tx_scheduler.sv - scoreboard bench for rs485_tx_scheduler
module tb_rs485_tx_scheduler;

  localparam int PRE_CYC  = 50;
  localparam int POST_CYC = 434;
  localparam int TO_CYC   = 5208;
  localparam int TX_LEN   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_full;
  logic [4:0] fifo_level;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       busy_m = 1'b0;
  logic       stall = 1'b0;
  logic       uart_tx_busy;
  logic       uart_tx_done = 1'b0;
  logic       en_rs485;
  logic       tx_timeout;
  logic       overflow;

  assign uart_tx_busy = busy_m | stall;

  always #5 clk = ~clk;

  rs485_tx_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .fifo_full     (fifo_full),
    .fifo_level    (fifo_level),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .uart_tx_done  (uart_tx_done),
    .en_rs485      (en_rs485),
    .tx_timeout    (tx_timeout),
    .overflow      (overflow)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] sb[$];
  int start_log[$];
  int done_log[$];
  int start_cnt = 0, done_cnt = 0, rise_cnt = 0, fall_cnt = 0, to_cnt = 0;
  int last_start = 0, last_done = 0, last_rise = 0, last_fall = 0, last_to = 0;
  int tx_cnt = 0;
  bit drop_next = 1'b0;
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output checks first, then the transmitter model reacts to this cycle
  always @(negedge clk) begin
    if (uart_tx_start) begin
      check_vec("start_while_busy", 32'(prev_busy), 32'd0);
      if (sb.size() == 0) check_vec("unexpected_start", 32'd1, 32'd0);
      else check_vec("tx_data", 32'(uart_tx_data), 32'(sb.pop_front()));
      start_cnt++;
      last_start = cyc;
      start_log.push_back(cyc);
    end
    if (en_rs485 && !prev_en) begin rise_cnt++; last_rise = cyc; end
    if (!en_rs485 && prev_en) begin fall_cnt++; last_fall = cyc; end
    if (tx_timeout) begin to_cnt++; last_to = cyc; end
    uart_tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        busy_m = 1'b0;
        uart_tx_done = 1'b1;
        done_cnt++;
        last_done = cyc;
        done_log.push_back(cyc);
      end
    end
    if (uart_tx_start) begin
      if (drop_next) drop_next = 1'b0;
      else begin busy_m = 1'b1; tx_cnt = TX_LEN; end
    end
    prev_en = en_rs485;
    prev_busy = busy_m | stall;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    if (sb.size() < 16) sb.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n = 0;
    while (start_cnt < target && n < budget) begin tick(); n++; end
    check_vec(tag, 32'(start_cnt >= target), 32'd1);
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    check_vec(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_falls(input int target, input int budget, input string tag);
    int n = 0;
    while (fall_cnt < target && n < budget) begin tick(); n++; end
    check_vec(tag, 32'(fall_cnt >= target), 32'd1);
  endtask

  task automatic wait_tos(input int target, input int budget, input string tag);
    int n = 0;
    while (to_cnt < target && n < budget) begin tick(); n++; end
    check_vec(tag, 32'(to_cnt >= target), 32'd1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int bs, br, bf, bt, bd;

    tick(3);
    check_vec("rst_en", 32'(en_rs485), 32'd0);
    check_vec("rst_start", 32'(uart_tx_start), 32'd0);
    check_vec("rst_data", 32'(uart_tx_data), 32'd0);
    check_vec("rst_level", 32'(fifo_level), 32'd0);
    check_vec("rst_full", 32'(fifo_full), 32'd0);
    check_vec("rst_timeout", 32'(tx_timeout), 32'd0);
    check_vec("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(2);

    // Single byte from IDLE
    bf = fall_cnt;
    w = cyc;
    write_byte(8'h03);
    wait_starts(1, 200, "t1_start_seen");
    check_vec("t1_latency", 32'(last_start - w), 32'(PRE_CYC + 3));
    check_vec("t1_en_rise", 32'(last_rise - w), 32'd2);
    wait_falls(bf + 1, 1000, "t1_fall_seen");
    check_vec("t1_post_len", 32'(last_fall - last_done - 1), 32'(POST_CYC));

    // Four-byte burst
    start_log.delete(); done_log.delete();
    bs = start_cnt; br = rise_cnt; bf = fall_cnt;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); sb.push_back(8'(i)); tick();
    end
    wr_en = 1'b0;
    wait_starts(bs + 4, 2000, "t2_starts_seen");
    wait_falls(bf + 1, 2000, "t2_fall_seen");
    for (int i = 1; i < 4; i++) check_vec("t2_gap", 32'(start_log[i] - done_log[i-1] - 1), 32'd1);
    check_vec("t2_rises", 32'(rise_cnt - br), 32'd1);
    check_vec("t2_falls", 32'(fall_cnt - bf), 32'd1);
    check_vec("t2_post_len", 32'(last_fall - last_done - 1), 32'(POST_CYC));

    // Byte arriving inside the post-guard
    bs = start_cnt; br = rise_cnt; bf = fall_cnt; bd = done_cnt;
    write_byte(8'h55);
    wait_dones(bd + 1, 400, "t3_done_seen");
    tick(100);
    check_vec("t3_en_held", 32'(en_rs485), 32'd1);
    w = cyc;
    write_byte(8'hAA);
    wait_starts(bs + 2, 100, "t3_start_seen");
    check_vec("t3_no_preguard", 32'(last_start - w), 32'd3);
    check_vec("t3_no_drop", 32'(fall_cnt - bf), 32'd0);
    wait_falls(bf + 1, 1000, "t3_fall_seen");
    check_vec("t3_post_restart", 32'(last_fall - last_done - 1), 32'(POST_CYC));
    check_vec("t3_rises", 32'(rise_cnt - br), 32'd1);

    // Fill with the transmitter stalled
    stall = 1'b1;
    bs = start_cnt; bf = fall_cnt;
    tick();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      if (sb.size() < 16) sb.push_back(wr_data);
      tick();
      if (i == 15) begin
        check_vec("t4_level16", 32'(fifo_level), 32'd16);
        check_vec("t4_full", 32'(fifo_full), 32'd1);
        check_vec("t4_no_ovf_yet", 32'(overflow), 32'd0);
      end
    end
    wr_en = 1'b0;
    check_vec("t4_overflow", 32'(overflow), 32'd1);
    check_vec("t4_level_held", 32'(fifo_level), 32'd16);
    tick(2);
    check_vec("t4_en_idle", 32'(en_rs485), 32'd0);
    stall = 1'b0;
    wait_starts(bs + 16, 16 * 40 + 200, "t4_starts_seen");
    wait_falls(bf + 1, 1000, "t4_fall_seen");
    tick(50);
    check_vec("t4_start_count", 32'(start_cnt - bs), 32'd16);
    check_vec("t4_sticky", 32'(overflow), 32'd1);
    check_vec("t4_drained", 32'(fifo_level), 32'd0);

    // Missing done pulse
    bs = start_cnt; bf = fall_cnt; bt = to_cnt; bd = done_cnt;
    drop_next = 1'b1;
    write_byte(8'hA5);
    wait_starts(bs + 1, 200, "t5_start_seen");
    wait_tos(bt + 1, TO_CYC + 100, "t5_timeout_seen");
    check_vec("t5_timeout_time", 32'(last_to - last_start), 32'(TO_CYC));
    wait_falls(bf + 1, 1000, "t5_fall_seen");
    check_vec("t5_post_len", 32'(last_fall - last_to), 32'(POST_CYC));
    check_vec("t5_no_done", 32'(done_cnt - bd), 32'd0);
    tick(3);
    w = cyc;
    write_byte(8'h5A);
    wait_starts(bs + 2, 200, "t5_next_seen");
    check_vec("t5_next_latency", 32'(last_start - w), 32'(PRE_CYC + 3));
    wait_falls(bf + 2, 1000, "t5_next_fall");
    check_vec("t5_single_timeout", 32'(to_cnt - bt), 32'd1);

    // Reset during WAIT_DONE with five bytes queued
    bs = start_cnt;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); sb.push_back(wr_data); tick();
    end
    wr_en = 1'b0;
    wait_starts(bs + 1, 200, "t6_start_seen");
    tick(5);
    check_vec("t6_level5", 32'(fifo_level), 32'd5);
    check_vec("t6_en_busy", 32'(en_rs485), 32'd1);
    rst = 1'b1;
    sb.delete();
    tick();
    check_vec("t6_level0", 32'(fifo_level), 32'd0);
    check_vec("t6_en_drop", 32'(en_rs485), 32'd0);
    tick(2);
    rst = 1'b0;
    bs = start_cnt;
    tick(300);
    check_vec("t6_no_start", 32'(start_cnt - bs), 32'd0);
    check_vec("t6_en_low", 32'(en_rs485), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
